// File: rtl/fifo_reader.sv
// rtl/fifo_reader.sv - FIFO read engine with 2-entry skid buffer and stream output
//
// Purpose: drives the read strobe of a synchronous FIFO with one-cycle read
// latency, captures each returned word into a 2-entry skid buffer and presents
// the buffer head on a valid/ready stream at one word per cycle.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   en             read enable; low stops new FIFO reads
//   fifo_empty     FIFO empty flag (registered by the FIFO)
//   fifo_data_out  FIFO read data, valid the cycle after a read strobe
//   fifo_rd_en     FIFO read strobe
//   m_data         stream data (skid buffer head)
//   m_valid        stream valid
//   m_ready        stream ready from sink
//   words_read     count of delivered words, wraps
module fifo_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  words_read
);

  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [CNT_WIDTH-1:0]  r_words_read;

  logic                  w_pop;
  logic [1:0]            w_held;
  logic [1:0]            w_occ_nxt;
  logic [DATA_WIDTH-1:0] w_head_nxt;
  logic [DATA_WIDTH-1:0] w_tail_nxt;

  assign w_pop = m_valid & m_ready;

  // Words that will still be owned after this edge. occ + inflight never
  // exceeds 2 and a pop implies occ >= 1, so this stays within 0..2. Counting
  // the pop here lets a read issue in the same cycle the sink frees a slot.
  assign w_held = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

  assign fifo_rd_en = rst & en & ~fifo_empty & (w_held < 2'd2);

  assign m_valid    = (r_occ != 2'd0);
  assign m_data     = r_head;
  assign words_read = r_words_read;

  always_comb begin
    w_occ_nxt  = r_occ;
    w_head_nxt = r_head;
    w_tail_nxt = r_tail;
    case ({r_inflight, w_pop})
      2'b01: begin
        // Pop only: tail slides into head.
        w_head_nxt = r_tail;
        w_occ_nxt  = r_occ - 2'd1;
      end
      2'b10: begin
        // Capture only: land in the first free slot.
        if (r_occ == 2'd0) begin
          w_head_nxt = fifo_data_out;
        end else begin
          w_tail_nxt = fifo_data_out;
        end
        w_occ_nxt = r_occ + 2'd1;
      end
      2'b11: begin
        // Capture with pop: occ must be 1 here, so the new word becomes head.
        w_head_nxt = fifo_data_out;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occ        <= 2'd0;
      r_inflight   <= 1'b0;
      r_head       <= '0;
      r_tail       <= '0;
      r_words_read <= '0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_inflight <= fifo_rd_en;
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      if (w_pop) begin
        r_words_read <= r_words_read + 1'b1;
      end
    end
  end

endmodule
